// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receive controller.
// Contents: FSM state enum, frame geometry (start/data/stop bit positions inside
// the receiver shift register) and the default inter-capture gap limit.
package uart_pkg;

  localparam int unsigned FRAME_BITS      = 10;  // start + 8 data + stop
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned START_IDX       = 1;
  localparam int unsigned STOP_IDX        = 10;
  localparam int unsigned GAP_MAX_DEFAULT = 7;   // nominal capture spacing is 5

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StEval
  } state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// DEPTH x DATA_W synchronous FIFO holding received bytes.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, wdata - write request and byte; accepted when not full or when popping
//   pop         - read request; ignored when empty
//   rdata       - head-of-FIFO byte (combinational from the read pointer)
//   full, empty - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is fine.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for the 2.5 MHz oversampling UART receiver: counts capture strobes,
// frames 10-bit characters, checks start/stop bits, buffers good bytes in a FIFO
// and flags framing errors, aborted frames and overruns.
// Ports:
//   CLK, RST_N  - clock, asynchronous active-low reset
//   CATCH       - receiver capture strobe (one cycle per bit)
//   SAMPLE      - receiver shift register, [1]=start, [9:2]=data, [10]=stop
//   DATA, VALID - head-of-FIFO byte and non-empty flag
//   READY       - consumer accepts DATA on VALID&READY
//   FERR, OVR   - sticky framing/abort error and overrun flags
//   CLR         - synchronous clear of FERR/OVR (and counters)
//   BUSY        - frame in progress
// Build option ERR_CNT_EN adds saturating 8-bit FERR_CNT/OVR_CNT event counters.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP_MAX = GAP_MAX_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CATCH,
  input  logic [10:1]       SAMPLE,
  output logic [DATA_W-1:0] DATA,
  output logic              VALID,
  input  logic              READY,
  output logic              FERR,
  output logic              OVR,
  input  logic              CLR,
  output logic              BUSY
`ifdef ERR_CNT_EN
  ,
  output logic [7:0]        FERR_CNT,
  output logic [7:0]        OVR_CNT
`endif
);

  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);
  localparam int unsigned GapW = $clog2(GAP_MAX + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FRAME_BITS - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_MAX - 1);
  localparam logic [BitW-1:0] BitOne  = BitW'(1);
  localparam logic [GapW-1:0] GapOne  = GapW'(1);

  state_e          state_q, state_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic            catch_q;
  logic            ferr_q, ferr_d, ovr_q, ovr_d;
  logic            ferr_set, ovr_set, push, pop, full, empty;

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .wdata (SAMPLE[9:2]),
    .pop   (pop),
    .rdata (DATA),
    .full  (full),
    .empty (empty)
  );

  assign VALID = ~empty;
  assign pop   = READY & ~empty;
  assign BUSY  = (state_q != StIdle);
  assign FERR  = ferr_q;
  assign OVR   = ovr_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ferr_set  = 1'b0;
    ovr_set   = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (catch_q) begin
          state_d   = StRecv;
          bit_cnt_d = BitOne;
          gap_cnt_d = '0;
        end
      end
      StRecv: begin
        if (catch_q) begin
          bit_cnt_d = bit_cnt_q + BitOne;
          gap_cnt_d = '0;
          if (bit_cnt_q == BitLast) begin
            state_d = StEval;
          end
        end else if (gap_cnt_q == GapLast) begin
          // Receiver stalled mid-frame: abort and report as a framing error.
          ferr_set  = 1'b1;
          state_d   = StIdle;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GapOne;
        end
      end
      StEval: begin
        state_d   = StIdle;
        bit_cnt_d = '0;
        gap_cnt_d = '0;
        if (!SAMPLE[START_IDX] && SAMPLE[STOP_IDX]) begin
          // A same-cycle pop makes room, so only a full FIFO without pop overruns.
          if (full && !pop) begin
            ovr_set = 1'b1;
          end else begin
            push = 1'b1;
          end
        end else begin
          ferr_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Set events win over a same-cycle clear.
  always_comb begin
    ferr_d = ferr_set | (ferr_q & ~CLR);
    ovr_d  = ovr_set  | (ovr_q  & ~CLR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      catch_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      catch_q   <= CATCH;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef ERR_CNT_EN
  logic [7:0] ferr_cnt_q, ferr_cnt_d, ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ferr_cnt_d = CLR ? 8'd0 : ferr_cnt_q;
    ovr_cnt_d  = CLR ? 8'd0 : ovr_cnt_q;
    if (ferr_set && ferr_cnt_d != 8'hFF) begin
      ferr_cnt_d = ferr_cnt_d + 8'd1;
    end
    if (ovr_set && ovr_cnt_d != 8'hFF) begin
      ovr_cnt_d = ovr_cnt_d + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ferr_cnt_q <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      ferr_cnt_q <= ferr_cnt_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign FERR_CNT = ferr_cnt_q;
  assign OVR_CNT  = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        catch_in = 1'b0;
  logic [10:1] sample = '0;
  logic [7:0]  data;
  logic        valid;
  logic        ready = 1'b0;
  logic        ferr, ovr;
  logic        clr = 1'b0;
  logic        busy;
`ifdef ERR_CNT_EN
  logic [7:0]  ferr_cnt, ovr_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .CATCH  (catch_in),
    .SAMPLE (sample),
    .DATA   (data),
    .VALID  (valid),
    .READY  (ready),
    .FERR   (ferr),
    .OVR    (ovr),
    .CLR    (clr),
    .BUSY   (busy)
`ifdef ERR_CNT_EN
    ,
    .FERR_CNT (ferr_cnt),
    .OVR_CNT  (ovr_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:1] mk_frame(input logic [7:0] d, input logic start_b,
                                           input logic stop_b);
    return {stop_b, d, start_b};
  endfunction

  // Shift n bits of frame into SAMPLE, one CATCH pulse every 5 cycles.
  // Returns on the negedge right after the posedge that registered the last pulse.
  task automatic send_bits(input int n, input logic [10:1] frame);
    logic [10:1] sh;
    sh = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sh       = {frame[i+1], sh[10:2]};
      sample   = sh;
      catch_in = 1'b1;
      @(negedge clk);
      catch_in = 1'b0;
      if (i != n - 1) repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(10, mk_frame(d, 1'b0, 1'b1));
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  logic [7:0] exp_q[$];

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", ferr, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame 0x55 and latency
    send_bits(10, mk_frame(8'h55, 1'b0, 1'b1));
    check("lat_busy", busy, 1'b1);
    @(negedge clk);
    check("lat_valid_early", valid, 1'b0);
    @(negedge clk);
    check("lat_valid", valid, 1'b1);
    check("lat_data", data, 8'h55);
    check("lat_ferr", ferr, 1'b0);
    check("lat_busy_done", busy, 1'b0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("pop55_valid", valid, 1'b0);

    // Bad stop bit
    send_bits(10, mk_frame(8'h55, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    check("badstop_valid", valid, 1'b0);
    check("badstop_ferr", ferr, 1'b1);
    pulse_clr();
    check("clr_ferr", ferr, 1'b0);

    // Gap timeout after four pulses
    send_bits(4, mk_frame(8'hA3, 1'b0, 1'b1));
    repeat (7) @(negedge clk);
    check("gap6_ferr", ferr, 1'b0);
    check("gap6_busy", busy, 1'b1);
    @(negedge clk);
    check("gap7_ferr", ferr, 1'b1);
    check("gap7_busy", busy, 1'b0);
    pulse_clr();
    send_byte(8'hA3);
    check("a3_valid", valid, 1'b1);
    check("a3_data", data, 8'hA3);
    check("a3_ferr", ferr, 1'b0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;

    // Overrun: five frames into a 4-deep FIFO
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k));
      if (k == 4) check("ovr_before", ovr, 1'b0);
    end
    check("ovr_after", ovr, 1'b1);
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("ovr_pop_valid", valid, 1'b1);
      check("ovr_pop_data", data, 32'(k));
      @(negedge clk);
    end
    ready = 1'b0;
    check("ovr_drained", valid, 1'b0);
    pulse_clr();
    check("clr_ovr", ovr, 1'b0);

    // Push into a full FIFO with a same-cycle pop
    for (int k = 0; k < 4; k++) send_byte(8'h11 + 8'(k));
    send_bits(10, mk_frame(8'h66, 1'b0, 1'b1));
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("pp_ovr", ovr, 1'b0);
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h66};
    ready = 1'b1;
    foreach (exp_q[i]) begin
      check("pp_valid", valid, 1'b1);
      check("pp_data", data, exp_q[i]);
      @(negedge clk);
    end
    ready = 1'b0;
    check("pp_drained", valid, 1'b0);

    // Reset mid-frame with a non-empty FIFO
    send_byte(8'h77);
    check("pre_rst_valid", valid, 1'b1);
    send_bits(6, mk_frame(8'h3C, 1'b0, 1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", valid, 1'b0);
    check("mrst_data", data, 8'h00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_ferr", ferr, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_bits(10, mk_frame(8'h3C, 1'b0, 1'b1));
    repeat (2) @(negedge clk);
    check("post_rst_valid", valid, 1'b1);
    check("post_rst_data", data, 8'h3C);
    check("post_rst_ferr", ferr, 1'b0);
    check("post_rst_ovr", ovr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
